// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and instruction fetcher with 2-entry decode buffer
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_address             word address to instruction memory (always the PC)
//   imem_instruction         combinational read data for imem_address
//   start, stop              run control (stop wins when both are high)
//   redirect_valid/target    load a new PC and flush the buffer
//   out_valid/ready          handshake toward decode
//   out_instruction, out_pc  head buffer entry (zero when the buffer is empty)
module instruction_fetch_unit #(
    parameter int         L        = 16,
    parameter logic [L-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [L-1:0] imem_address,
    input  logic [L-1:0] imem_instruction,
    input  logic         start,
    input  logic         stop,
    input  logic         redirect_valid,
    input  logic [L-1:0] redirect_target,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [L-1:0] out_instruction,
    output logic [L-1:0] out_pc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    logic [L-1:0] pc;
    logic [1:0]   count;

    // Shift-style buffer: e0 is always the head, e1 the entry behind it.
    logic [L-1:0] e0_pc;
    logic [L-1:0] e0_ins;
    logic [L-1:0] e1_pc;
    logic [L-1:0] e1_ins;

    logic pop;
    logic push;

    assign pop  = (count != 2'd0) && out_ready;
    // A full buffer can still accept when the head leaves in the same cycle.
    assign push = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);

    assign imem_address    = pc;
    assign out_valid       = (count != 2'd0);
    // Stale head contents are masked so an empty buffer presents zeros.
    assign out_pc          = out_valid ? e0_pc  : '0;
    assign out_instruction = out_valid ? e0_ins : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            count  <= 2'd0;
            e0_pc  <= '0;
            e0_ins <= '0;
            e1_pc  <= '0;
            e1_ins <= '0;
        end else begin
            // State transitions apply even during a redirect.
            case (state)
                IDLE: if (start && !stop) state <= RUN;
                RUN:  if (stop)           state <= IDLE;
                default:                  state <= IDLE;
            endcase

            if (redirect_valid) begin
                // A pop this cycle is simply dropped along with the rest.
                pc    <= redirect_target;
                count <= 2'd0;
            end else begin
                if (push) begin
                    pc <= pc + L'(1);
                end

                if (push && !pop) begin
                    count <= count + 2'd1;
                end else if (pop && !push) begin
                    count <= count - 2'd1;
                end

                if (pop) begin
                    if (count == 2'd2) begin
                        e0_pc  <= e1_pc;
                        e0_ins <= e1_ins;
                        if (push) begin
                            e1_pc  <= pc;
                            e1_ins <= imem_instruction;
                        end
                    end else if (push) begin
                        e0_pc  <= pc;
                        e0_ins <= imem_instruction;
                    end
                end else if (push) begin
                    if (count == 2'd0) begin
                        e0_pc  <= pc;
                        e0_ins <= imem_instruction;
                    end else begin
                        e1_pc  <= pc;
                        e1_ins <= imem_instruction;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, redirect_valid, out_ready;
    logic [15:0] redirect_target;
    logic [15:0] imem_address, imem_instruction, out_instruction, out_pc;
    logic        out_valid;

    logic        start2, ready2;
    logic [15:0] imem_address2, imem_instruction2, out_instruction2, out_pc2;
    logic        out_valid2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a <= 16'd30) ? a : 16'd0;
    endfunction

    assign imem_instruction  = mem(imem_address);
    assign imem_instruction2 = mem(imem_address2);

    instruction_fetch_unit #(.L(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_address(imem_address), .imem_instruction(imem_instruction),
        .start(start), .stop(stop),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc)
    );

    instruction_fetch_unit #(.L(16), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_address(imem_address2), .imem_instruction(imem_instruction2),
        .start(start2), .stop(1'b0),
        .redirect_valid(1'b0), .redirect_target(16'h0000),
        .out_valid(out_valid2), .out_ready(ready2),
        .out_instruction(out_instruction2), .out_pc(out_pc2)
    );

    // Reference model: a queue of fetched {pc, instruction}, a PC and a run flag.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } entry_t;

    entry_t      q[$];
    logic [15:0] m_pc;
    logic        m_run;

    logic [48:0] dutv;
    assign dutv = {out_valid, out_pc, out_instruction, imem_address};

    function automatic logic [48:0] expv();
        if (q.size() != 0) return {1'b1, q[0].pc, q[0].ins, m_pc};
        return {1'b0, 32'd0, m_pc};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc  = 16'h0000;
        m_run = 1'b0;
    endtask

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic tick();
        entry_t      nq[$];
        entry_t      e;
        logic [15:0] npc;
        logic        nrun, pop, push;
        nq   = q;
        npc  = m_pc;
        nrun = m_run;
        pop  = (q.size() != 0) && out_ready;
        push = m_run && !redirect_valid && ((q.size() < 2) || pop);
        if (redirect_valid) begin
            nq.delete();
            npc = redirect_target;
        end else begin
            if (pop) void'(nq.pop_front());
            if (push) begin
                e.pc  = m_pc;
                e.ins = mem(m_pc);
                nq.push_back(e);
                npc = m_pc + 16'd1;
            end
        end
        if (m_run && stop) nrun = 1'b0;
        else if (!m_run && start && !stop) nrun = 1'b1;
        @(posedge clk);
        #1;
        q     = nq;
        m_pc  = npc;
        m_run = nrun;
    endtask

    task automatic apply_reset();
        start = 0; stop = 0; redirect_valid = 0; redirect_target = 0; out_ready = 0;
        start2 = 0; ready2 = 0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        tests++; if (out_pc !== 16'h0) begin fails++; $display("FAIL reset_out_pc: got %h expected 0000", out_pc); end
        tests++; if (out_instruction !== 16'h0) begin fails++; $display("FAIL reset_out_ins: got %h expected 0000", out_instruction); end
        tests++; if (imem_address !== 16'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0000", imem_address); end
        tests++; if (imem_address2 !== 16'hFFFE) begin fails++; $display("FAIL reset_addr_wrap: got %h expected fffe", imem_address2); end
    endtask

    task automatic test_sequential();
        apply_reset();
        start = 1; tick(); start = 0; out_ready = 1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL seq_latency1: got valid %b expected 0", out_valid); end
        tick();
        for (int k = 0; k <= 31; k++) begin
            logic [15:0] eins;
            eins = (k <= 30) ? 16'(k) : 16'h0;
            tests++;
            if ({out_valid, out_pc, out_instruction} !== {1'b1, 16'(k), eins}) begin
                fails++;
                $display("FAIL seq_k%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", k, out_valid, out_pc, out_instruction, 16'(k), eins);
            end
            tests++; if (dutv !== expv()) begin fails++; $display("FAIL seq_model_k%0d: got %h expected %h", k, dutv, expv()); end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        start = 1; tick(); start = 0; out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++; if (dutv !== expv()) begin fails++; $display("FAIL bp_fill_%0d: got %h expected %h", i, dutv, expv()); end
        end
        tests++;
        if ({out_valid, out_pc, out_instruction, imem_address} !== {1'b1, 16'd0, 16'd0, 16'd2}) begin
            fails++;
            $display("FAIL bp_stall: got v=%b pc=%h ins=%h addr=%h expected v=1 pc=0000 ins=0000 addr=0002", out_valid, out_pc, out_instruction, imem_address);
        end
        out_ready = 1;
        for (int k = 0; k <= 4; k++) begin
            tests++;
            if ({out_valid, out_pc} !== {1'b1, 16'(k)}) begin
                fails++; $display("FAIL bp_drain_k%0d: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, 16'(k));
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        tests++; if (dutv !== expv()) begin fails++; $display("FAIL rd_full: got %h expected %h", dutv, expv()); end
        redirect_valid = 1; redirect_target = 16'd20;
        tick();
        redirect_valid = 0;
        tests++;
        if ({out_valid, imem_address} !== {1'b0, 16'd20}) begin
            fails++; $display("FAIL rd_flush: got v=%b addr=%h expected v=0 addr=0014", out_valid, imem_address);
        end
        tick();
        out_ready = 1;
        for (int k = 20; k <= 22; k++) begin
            tests++;
            if ({out_valid, out_pc, out_instruction} !== {1'b1, 16'(k), 16'(k)}) begin
                fails++; $display("FAIL rd_seq_%0d: got v=%b pc=%h ins=%h expected pc=ins=%h", k, out_valid, out_pc, out_instruction, 16'(k));
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [15:0] eins [4];
        eins[0] = 16'h0; eins[1] = 16'h0; eins[2] = 16'h0; eins[3] = 16'h1;
        apply_reset();
        start2 = 1; tick(); start2 = 0; ready2 = 1; tick();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] epc;
            epc = 16'hFFFE + 16'(k);
            tests++;
            if ({out_valid2, out_pc2, out_instruction2} !== {1'b1, epc, eins[k]}) begin
                fails++; $display("FAIL wrap_k%0d: got v=%b pc=%h ins=%h expected pc=%h ins=%h", k, out_valid2, out_pc2, out_instruction2, epc, eins[k]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1; tick(); start = 0; out_ready = 1; tick(); tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ar_pre: got valid %b expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, imem_address} !== {1'b0, 16'd0}) begin
            fails++; $display("FAIL ar_immediate: got v=%b addr=%h expected v=0 addr=0000", out_valid, imem_address);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({out_valid, imem_address} !== {1'b0, 16'd0}) begin
                fails++; $display("FAIL ar_idle_%0d: got v=%b addr=%h expected v=0 addr=0000", i, out_valid, imem_address);
            end
        end
    endtask

    task automatic test_stop();
        apply_reset();
        start = 1; tick(); start = 0; out_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        stop = 1; tick(); stop = 0;
        tests++;
        if ({out_valid, out_pc, imem_address} !== {1'b1, 16'd0, 16'd2}) begin
            fails++; $display("FAIL stop_full: got v=%b pc=%h addr=%h expected v=1 pc=0000 addr=0002", out_valid, out_pc, imem_address);
        end
        out_ready = 1;
        tick();
        tests++;
        if ({out_valid, out_pc} !== {1'b1, 16'd1}) begin
            fails++; $display("FAIL stop_drain1: got v=%b pc=%h expected v=1 pc=0001", out_valid, out_pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({out_valid, imem_address} !== {1'b0, 16'd2}) begin
                fails++; $display("FAIL stop_frozen_%0d: got v=%b addr=%h expected v=0 addr=0002", i, out_valid, imem_address);
            end
        end
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({out_valid, imem_address} !== {1'b0, 16'd2}) begin
                fails++; $display("FAIL startstop_idle_%0d: got v=%b addr=%h expected v=0 addr=0002", i, out_valid, imem_address);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            start          = ($urandom_range(0, 5) == 0);
            stop           = ($urandom_range(0, 15) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                          : 16'($urandom_range(0, 40));
            out_ready      = $urandom_range(0, 1);
            tick();
            tests++; if (dutv !== expv()) begin fails++; $display("FAIL rand_%0d: got %h expected %h", i, dutv, expv()); end
        end
        start = 0; stop = 0; redirect_valid = 0; out_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_back_pressure();
        test_redirect_full();
        test_wrap();
        test_async_reset();
        test_stop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Read-side initiator for the instruction memory: owns the program counter, drives the memory's word address, captures the combinationally returned instruction and presents it to decode through a valid/ready handshake. It sits between the instruction memory and the decode stage. A 2-entry buffer absorbs decode back-pressure, and a redirect port accepts branch/jump targets that flush the buffer.

## Interface
- `L`, 16, instruction and address width in bits (memory is word-addressed: one instruction per address)
- `RESET_PC`, 0, PC value loaded on reset
- `clk` input 1 — single clock, all state updates on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `imem_address` output L — word address to instruction memory; always equals `pc`
- `imem_instruction` input L — memory read data, valid in the same cycle as `imem_address` (combinational memory)
- `start` input 1 — begin fetching (sampled in IDLE)
- `stop` input 1 — cease fetching (sampled in RUN)
- `redirect_valid` input 1 — load new PC and flush buffer
- `redirect_target` input L — new PC value
- `out_valid` output 1 — head buffer entry is valid
- `out_ready` input 1 — decode accepts head entry this cycle
- `out_instruction` output L — head entry instruction
- `out_pc` output L — address the head instruction was fetched from

## Operation
- State machine: IDLE, RUN. IDLE + `start` → RUN. RUN + `stop` → IDLE. `start` and `stop` asserted together: the block goes to, or stays in, IDLE (`stop` wins). `start` in RUN and `stop` in IDLE are ignored.
- Buffer: 2-entry FIFO of {pc, instruction}. The head drives `out_pc`/`out_instruction`. `out_valid` = (count != 0).
- Pop: `out_valid && out_ready`.
- Push: state == RUN && !`redirect_valid` && (count < 2 || pop). A push writes {`pc`, `imem_instruction`} and sets `pc` <= `pc` + 1, modulo 2^L (0xFFFF wraps to 0x0000 for L=16). Push and pop may occur in the same cycle; count is unchanged when the buffer is full.
- No push: `pc` holds. `imem_address` stays at the unfetched PC.
- Redirect (any state):
  - `pc` <= `redirect_target` and count <= 0.
  - No push occurs that cycle.
  - Any pop in that cycle counts as consumed by decode.
  - The state is unchanged, so a redirect in IDLE only loads the PC.
  - Redirect has priority over push, pop, start and stop effects on `pc` and the buffer; state transitions still apply.
- `stop`: the buffer is retained and keeps draining to decode. No further pushes occur until the next `start`.
- Head stability: while `out_valid && !out_ready`, `out_pc` and `out_instruction` are held constant.
- When the buffer is empty, `out_instruction` and `out_pc` are 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `pc` = `RESET_PC`, count = 0.
  - `imem_address` = `RESET_PC`.
  - `out_valid` = 0, `out_instruction` = 0, `out_pc` = 0.
- Reset asserted mid-operation discards all buffered entries. After release the block waits in IDLE for `start`.
- `start` sampled at edge E0:
  - RUN begins in cycle 1 and the first push happens in that cycle.
  - `out_valid` = 1 with `out_pc` = `RESET_PC` in cycle 2. Latency is 2 cycles.
- Redirect sampled at edge E0:
  - Cycle 1: `out_valid` = 0 and `imem_address` = target; the target instruction is pushed (if in RUN).
  - Cycle 2: `out_valid` = 1 with `out_pc` = target. Redirect latency is 2 cycles.
- Throughput: with `out_ready` held high in RUN, one instruction per cycle, with no gaps or duplicates.
- Back-pressure: with `out_ready` low, the buffer fills in 2 cycles, then `pc` stalls. When `out_ready` rises, issue resumes in the same cycle and no instruction is skipped.

## Test plan
The bench uses the project instruction memory image: word n holds value n for n ≤ 30, and 0 for all higher addresses.

- **Sequential fetch:** reset, pulse `start`, `out_ready`=1 → `out_valid` first high 2 cycles after `start`. Outputs run `out_pc`=0,1,2,…,30,31 with `out_instruction` = `out_pc` up to 30, and 0x0000 at 31.
- **Back-pressure:** `start`, hold `out_ready`=0 for 6 cycles → count reaches 2. `imem_address` holds at 2 and the head stays at pc 0 / instruction 0. Release `out_ready` → `out_pc` sequence 0,1,2,3,4 with no gaps or repeats.
- **Redirect on full buffer:** full buffer, `out_ready`=0, `redirect_valid`=1 with target 20 → next cycle `out_valid`=0 and `imem_address`=20. The following cycle `out_pc`=20 and `out_instruction`=20, then 21, 22.
- **Wrap-around:** `RESET_PC`=0xFFFE, `start`, `out_ready`=1 → `out_pc` = 0xFFFE, 0xFFFF, 0x0000, 0x0001 with instructions 0, 0, 0, 1.
- **Async reset mid-run:** assert `rst` between clock edges while `out_valid`=1 → `out_valid`=0 and `imem_address`=`RESET_PC` before the next edge. After release, no fetch occurs until `start`.
- **Stop and simultaneous start/stop:**
  - `stop` in RUN with 2 buffered entries → exactly those 2 entries drain, and `pc` stays frozen.
  - `start` and `stop` asserted together in IDLE → the block remains in IDLE and `out_valid` stays 0.
